led_pattern_driver: RTL and testbench

Parametrised successor to the combinational LED index decoder. It drives a bank of NUM_LEDS board LEDs (LEDR) from a registered LED index plus a display mode: one-hot, bar-graph, blink and chase. Blink and chase run from an internal tick divider. It sits between game/control logic and the board LED pins. It flags indices that are out of range instead of silently showing nothing.

---
 rtl/led_pattern_driver.sv | 133 +++++++++++++
 tb/tb_led_pattern_driver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_driver.sv
// LED bank driver: latched index + display mode (one-hot, bar, blink, chase) with tick-based animation.
// Optional brightness gating by a free-running PWM counter when LED_PWM_EN is defined.
module led_pattern_driver #(
    parameter int NUM_LEDS = 10,
    parameter int IDX_W    = 4,
    parameter int TICK_DIV = 25000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [IDX_W-1:0]    led_number,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] LEDR,
    output logic                range_err
);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'd0,
        MODE_BAR    = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W:0]    NUM_L    = (IDX_W + 1)'(NUM_LEDS);
    localparam logic [IDX_W-1:0]  POS_LAST = IDX_W'(NUM_LEDS - 1);

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < NUM_L);
    endfunction

    function automatic logic [NUM_LEDS-1:0] onehot_pat(input logic [IDX_W-1:0] idx);
        logic [NUM_LEDS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_LEDS; i++) p[i] = (idx == IDX_W'(i));
        return p;
    endfunction

    // Indices past the last LED light every bit, i.e. the bar saturates.
    function automatic logic [NUM_LEDS-1:0] bar_sat(input logic [IDX_W-1:0] top);
        logic [NUM_LEDS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_LEDS; i++) p[i] = (IDX_W'(i) <= top);
        return p;
    endfunction

    logic                vld_p0;
    logic [IDX_W-1:0]    num_p0;
    mode_e               mode_p0;
    logic [CNT_W-1:0]    cnt_p0;
    logic                phase_p0;
    logic [IDX_W-1:0]    pos_p0;
    logic                tick;
    logic                gate;
    logic [NUM_LEDS-1:0] pat;

    assign tick = (cnt_p0 == CNT_MAX);

    // Stage p0: latched request plus animation state; a load overrides any coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            num_p0   <= '0;
            mode_p0  <= MODE_ONEHOT;
            cnt_p0   <= '0;
            phase_p0 <= 1'b1;
            pos_p0   <= '0;
        end else if (load) begin
            vld_p0   <= 1'b1;
            num_p0   <= led_number;
            mode_p0  <= mode_e'(mode);
            cnt_p0   <= '0;
            phase_p0 <= 1'b1;
            pos_p0   <= in_range(led_number) ? led_number : '0;
        end else if (tick) begin
            cnt_p0   <= '0;
            phase_p0 <= ~phase_p0;
            pos_p0   <= (pos_p0 == POS_LAST) ? '0 : pos_p0 + 1'b1;
        end else begin
            cnt_p0   <= cnt_p0 + 1'b1;
        end
    end

    always_comb begin
        pat = '0;
        if (vld_p0) begin
            case (mode_p0)
                MODE_ONEHOT: pat = onehot_pat(num_p0);
                MODE_BAR:    pat = bar_sat(num_p0);
                MODE_BLINK:  pat = phase_p0 ? onehot_pat(num_p0) : '0;
                MODE_CHASE:  pat = onehot_pat(pos_p0);
                default:     pat = '0;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            bright_p0 <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (load) bright_p0 <= brightness;
        end
    end

    // All-ones must mean fully on, which the strict compare alone cannot reach.
    assign gate = (&bright_p0) | (pwm_cnt < bright_p0);
`else
    logic brightness_unused;
    assign brightness_unused = ^brightness;
    assign gate = 1'b1;
`endif

    // Stage p1: registered LED drive and range flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            LEDR      <= '0;
            range_err <= 1'b0;
        end else begin
            LEDR      <= pat & {NUM_LEDS{gate}};
            range_err <= ~in_range(num_p0);
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with NUM_LEDS=10, IDX_W=4, TICK_DIV=4, PWM_BITS=4.
module tb_led_pattern_driver;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] led_number;
    logic [1:0] mode;
    logic [3:0] brightness;
    logic [9:0] LEDR;
    logic       range_err;

    int total = 0;
    int bad   = 0;

    led_pattern_driver #(
        .NUM_LEDS(10),
        .IDX_W   (4),
        .TICK_DIV(4),
        .PWM_BITS(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .led_number(led_number),
        .mode      (mode),
        .brightness(brightness),
        .LEDR      (LEDR),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] n, input logic [1:0] m);
        led_number = n;
        mode       = m;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        led_number = '0;
        mode       = '0;
        brightness = 4'hF;
        step();
        step();
        check("reset_ledr", 32'(LEDR), 32'h0);
        check("reset_err", 32'(range_err), 32'h0);
        reset = 1'b0;
        step();
        step();
        step();
        check("noload_ledr", 32'(LEDR), 32'h0);

        // one-hot with two-edge latency
        do_load(4'd3, 2'd0);
        check("onehot_lat1", 32'(LEDR), 32'h0);
        step();
        check("onehot3", 32'(LEDR), 32'h008);
        check("onehot3_err", 32'(range_err), 32'h0);

        // bar sweep and saturation
        for (int n = 0; n < 10; n++) begin
            do_load(4'(n), 2'd1);
            step();
            check($sformatf("bar%0d", n), 32'(LEDR), (32'd1 << (n + 1)) - 32'd1);
        end
        do_load(4'd12, 2'd1);
        step();
        check("bar12_sat", 32'(LEDR), 32'h3FF);
        check("bar12_err", 32'(range_err), 32'h1);
        do_load(4'd2, 2'd1);
        step();
        check("bar2", 32'(LEDR), 32'h007);
        check("bar2_err", 32'(range_err), 32'h0);

        // blink: on 4, off 4, on 4, then reload mid-off
        do_load(4'd5, 2'd2);
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("blink_e%0d", j), 32'(LEDR), (((j - 1) / 4) % 2 == 0) ? 32'h020 : 32'h0);
        end
        step();
        step();
        check("blink_off_mid", 32'(LEDR), 32'h0);
        do_load(4'd5, 2'd2);
        check("blink_reload_lat", 32'(LEDR), 32'h0);
        step();
        check("blink_reload_on", 32'(LEDR), 32'h020);

        // chase from 8 with wrap
        do_load(4'd8, 2'd3);
        for (int j = 1; j <= 16; j++) begin
            step();
            check($sformatf("chase_e%0d", j), 32'(LEDR), 32'd1 << ((8 + (j - 1) / 4) % 10));
        end
        step();
        step();
        step();
        check("chase_pos2", 32'(LEDR), 32'h004);
        // this load lands on a tick edge
        do_load(4'd4, 2'd3);
        check("chase_tickload_lat", 32'(LEDR), 32'h004);
        for (int j = 1; j <= 4; j++) begin
            step();
            check($sformatf("chase_hold4_e%0d", j), 32'(LEDR), 32'h010);
        end
        step();
        check("chase_adv5", 32'(LEDR), 32'h020);

        // out-of-range handling
        do_load(4'd15, 2'd0);
        step();
        check("oor_onehot", 32'(LEDR), 32'h0);
        check("oor_onehot_err", 32'(range_err), 32'h1);
        do_load(4'd15, 2'd3);
        step();
        check("oor_chase", 32'(LEDR), 32'h001);
        check("oor_chase_err", 32'(range_err), 32'h1);
        do_load(4'd1, 2'd2);
        step();
        check("blink1", 32'(LEDR), 32'h002);
        check("blink1_err", 32'(range_err), 32'h0);
        do_load(4'd11, 2'd2);
        step();
        step();
        check("oor_blink_err", 32'(range_err), 32'h1);

        // asynchronous reset mid-animation
        do_load(4'd1, 2'd2);
        step();
        step();
        check("pre_reset", 32'(LEDR), 32'h002);
        #2 reset = 1'b1;
        #1;
        check("async_ledr", 32'(LEDR), 32'h0);
        check("async_err", 32'(range_err), 32'h0);
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check("post_reset_ledr", 32'(LEDR), 32'h0);
        check("post_reset_err", 32'(range_err), 32'h0);

`ifdef LED_PWM_EN
        begin
            int lit;
            brightness = 4'd4;
            do_load(4'd0, 2'd0);
            step();
            lit = 0;
            for (int j = 0; j < 16; j++) begin
                lit += int'(LEDR[0]);
                step();
            end
            check("pwm_b4", 32'(lit), 32'd4);
            brightness = 4'd15;
            do_load(4'd0, 2'd0);
            step();
            lit = 0;
            for (int j = 0; j < 16; j++) begin
                lit += int'(LEDR[0]);
                step();
            end
            check("pwm_b15", 32'(lit), 32'd16);
            brightness = 4'd0;
            do_load(4'd0, 2'd0);
            step();
            lit = 0;
            for (int j = 0; j < 16; j++) begin
                lit += int'(LEDR[0]);
                step();
            end
            check("pwm_b0", 32'(lit), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
